// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment controller.
// Contents: segment patterns, converter state type, nibble decoder and a power-of-ten helper.
package seg_pkg;

    // Active-low segment patterns, bit order {a,b,c,d,e,f,g}.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Elaboration-time 10^n; 32 bits covers up to eight digits.
    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready input and a done strobe.
// One input bit is consumed per SHIFT cycle; done is high for the single COMMIT cycle.
module seg_bin2bcd
    import seg_pkg::*;
#(
    parameter int BIN_W    = 13,
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [BIN_W-1:0]      value,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf_next,
    output logic [N_DIGITS*4-1:0] bcd
);

    localparam int BCD_W = N_DIGITS * 4;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [31:0] MAX_VAL = pow10(N_DIGITS) - 32'd1;

    conv_state_e      state_q;
    logic [BIN_W-1:0] sr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] adj_d;
    logic             in_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;

    // Add-3 correction on every nibble that would reach 10 or more after doubling.
    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_adj
            assign adj_d[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                      (bcd_q[gi*4 +: 4] + 4'd3) :
                                      bcd_q[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        sr_q       <= value;
                        bcd_q      <= '0;
                        cnt_q      <= CNT_W'(BIN_W - 1);
                        ovf_q      <= (32'(value) > MAX_VAL);
                        state_q    <= ST_SHIFT;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // The carry out of the top nibble is dropped; overflow is flagged separately.
                    bcd_q <= {adj_d[BCD_W-2:0], sr_q[BIN_W-1]};
                    sr_q  <= sr_q << 1;
                    if (cnt_q == '0) begin
                        state_q <= ST_COMMIT;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ovf_next = ovf_q;
    assign bcd      = bcd_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed active-low seven-segment display controller: BCD conversion, atomic commit, digit scan.
// Define SEVSEG_LZB_EN to blank leading zeros (rightmost digit always shown, not applied on overflow).
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int BIN_W     = 13,
    parameter int REFRESH_W = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_W-1:0]    value,
    output logic                busy,
    output logic                ovf,
    output logic [N_DIGITS-1:0] anode,
    output logic [6:0]          seg
);

    localparam int BCD_W = N_DIGITS * 4;
    localparam int DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic             conv_done;
    logic             conv_ovf;
    logic [BCD_W-1:0] conv_bcd;

    seg_bin2bcd #(
        .BIN_W    (BIN_W),
        .N_DIGITS (N_DIGITS)
    ) u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .value    (value),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (conv_done),
        .ovf_next (conv_ovf),
        .bcd      (conv_bcd)
    );

    logic [BCD_W-1:0]     disp_q;
    logic                 ovf_q;
    logic [REFRESH_W-1:0] presc_q;
    logic [DIG_W-1:0]     dig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else if (conv_done) begin
            disp_q <= conv_bcd;
            ovf_q  <= conv_ovf;
        end
    end

    // Digit index steps on the edge where the prescaler sits at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            dig_q   <= '0;
        end else begin
            presc_q <= presc_q + REFRESH_W'(1);
            if (&presc_q) begin
                dig_q <= (dig_q == DIG_W'(N_DIGITS - 1)) ? '0 : (dig_q + DIG_W'(1));
            end
        end
    end

    logic [N_DIGITS-1:0] lz_blank;

`ifdef SEVSEG_LZB_EN
    logic [N_DIGITS-1:0] nib_zero;
    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_lzb
            assign nib_zero[gi] = (disp_q[gi*4 +: 4] == 4'd0);
            if (gi == 0) begin : g_units
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = &nib_zero[N_DIGITS-1:gi];
            end
        end
    endgenerate
`else
    assign lz_blank = '0;
`endif

    logic [3:0]          cur_nib;
    logic                cur_blank;
    logic [N_DIGITS-1:0] anode_d;
    logic [6:0]          seg_d;

    // Nibble position i (0 = rightmost) is lit when d == N_DIGITS-1-i.
    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        anode_d   = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (dig_q == DIG_W'(N_DIGITS - 1 - i)) begin
                cur_nib    = disp_q[i*4 +: 4];
                cur_blank  = lz_blank[i];
                anode_d[i] = 1'b0;
            end
        end
        if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (cur_blank) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_decode(cur_nib);
        end
    end

    assign anode = anode_d;
    assign seg   = seg_d;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: arithmetic reference model, per-cycle compare, directed and random values.
module tb_seg_display_ctrl;

    localparam int N  = 4;
    localparam int BW = 14;
    localparam int RW = 3;
    localparam int unsigned MAXV = 9999;

`ifdef SEVSEG_LZB_EN
    localparam logic [6:0] LEAD0 = 7'b1111111;
`else
    localparam logic [6:0] LEAD0 = 7'b0000001;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [BW-1:0] value = '0;
    logic          in_ready;
    logic          busy;
    logic          ovf;
    logic [N-1:0]  anode;
    logic [6:0]    seg;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    always #5 clk = ~clk;

    seg_display_ctrl #(
        .N_DIGITS  (N),
        .BIN_W     (BW),
        .REFRESH_W (RW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .value    (value),
        .busy     (busy),
        .ovf      (ovf),
        .anode    (anode),
        .seg      (seg)
    );

    logic [6:0] segtab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned p10(input int p);
        int unsigned r;
        r = 1;
        for (int i = 0; i < p; i++) r = r * 10;
        return r;
    endfunction

    // Expected pattern of decimal position p (0 = rightmost) for a committed value.
    function automatic logic [6:0] exp_seg(input int unsigned v, input bit o, input int p);
        if (o) return 7'b1111110;
`ifdef SEVSEG_LZB_EN
        if (p > 0 && v < p10(p)) return 7'b1111111;
`endif
        return segtab[(v / p10(p)) % 10];
    endfunction

    // Reference model: a conversion is a countdown of BW+1 cycles after acceptance.
    int unsigned m_cnt;
    int          m_left;
    int unsigned m_pend;
    int unsigned m_disp;
    bit          m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_left <= 0;
            m_pend <= 0;
            m_disp <= 0;
            m_ovf  <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_left == 0) begin
                if (in_valid) begin
                    m_pend <= value;
                    m_left <= BW + 1;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_disp <= m_pend;
                    m_ovf  <= (m_pend > MAXV);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started && !rst) begin
            int d;
            int p;
            logic [N-1:0] ea;
            d = (m_cnt >> RW) % N;
            p = N - 1 - d;
            ea = '1;
            ea[p] = 1'b0;
            chk("in_ready", in_ready, (m_left == 0));
            chk("busy", busy, (m_left != 0));
            chk("ovf", ovf, m_ovf);
            chk("anode", anode, ea);
            chk("seg", seg, exp_seg(m_disp, m_ovf, p));
        end
    end

    task automatic send(input int unsigned v);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_ready_timeout", in_ready, 1);
        $display("send value=%0d", v);
        in_valid = 1'b1;
        value    = BW'(v);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("idle_timeout", in_ready, 1);
    endtask

    task automatic wait_digit(input string name, input logic [N-1:0] a, input logic [6:0] s);
        int n;
        n = 0;
        while (anode !== a && n < 4 * N * (1 << RW)) begin
            @(negedge clk);
            n++;
        end
        if (anode !== a) chk({name, "_anode_timeout"}, anode, a);
        else chk(name, seg, s);
    endtask

    initial begin
        int n;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        started = 1'b1;

        chk("rst_anode", anode, 4'b0111);
        chk("rst_seg", seg, LEAD0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);

        send(1234);
        n = 0;
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("ready_low_cycles", n, BW + 1);
        wait_digit("d1234_0", 4'b0111, 7'b1001111);
        wait_digit("d1234_1", 4'b1011, 7'b0010010);
        wait_digit("d1234_2", 4'b1101, 7'b0000110);
        wait_digit("d1234_3", 4'b1110, 7'b1001100);
        chk("ovf_1234", ovf, 0);

        send(9999);
        wait_idle();
        wait_digit("d9999", 4'b0111, 7'b0000100);
        chk("ovf_9999", ovf, 0);

        send(10000);
        wait_idle();
        chk("ovf_10000", ovf, 1);
        wait_digit("dash", 4'b1011, 7'b1111110);

        send(7);
        wait_idle();
        wait_digit("d7_lead", 4'b0111, LEAD0);
        wait_digit("d7_units", 4'b1110, 7'b0001111);

        // Held valid: 42 is committed, 99 taken only at the next idle cycle.
        wait_idle();
        $display("send value=42 held, then 99");
        in_valid = 1'b1;
        value    = BW'(42);
        repeat (4) @(negedge clk);
        value    = BW'(99);
        @(negedge clk);
        wait_idle();
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle();
        wait_digit("d99_tens", 4'b1101, 7'b0000100);
        wait_digit("d99_units", 4'b1110, 7'b0000100);

        // Reset during SHIFT of 5555.
        send(5555);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_anode", anode, 4'b0111);
        chk("abort_seg", seg, LEAD0);
        chk("abort_ready", in_ready, 1);

        send(0);
        wait_idle();
        wait_digit("d0_units", 4'b1110, 7'b0000001);
        send((1 << BW) - 1);
        wait_idle();

        for (int t = 0; t < 60; t++) begin
            int unsigned v;
            repeat ($urandom_range(0, 20)) @(negedge clk);
            v = $urandom_range(0, (1 << BW) - 1);
            if ($urandom_range(0, 3) != 0) v = v % 10000;
            send(v);
            if (t == 30) begin
                repeat ($urandom_range(1, BW)) @(negedge clk);
                $display("reset pulse mid-conversion");
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        wait_idle();
        repeat (2 * N * (1 << RW)) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
